// File: rtl/ringbuf_mc.sv
// rtl/ringbuf_mc.sv - multi-channel circular sample store with tap reads, fill level and sticky flags
// Each channel owns one RAM plus pointers; a pop and a push in the same cycle let a full channel stream.
module ringbuf_mc #(
  parameter int NUM_CH      = 2,
  parameter int WIDTH       = 24,
  parameter int LEN_LOG2    = 6,
  parameter int READY_LEVEL = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH*WIDTH-1:0]      data_i,
  input  logic [NUM_CH-1:0]            we_i,
  input  logic [NUM_CH-1:0]            pop_i,
  input  logic [NUM_CH*LEN_LOG2-1:0]   offset_i,
  input  logic [NUM_CH-1:0]            clr_flags_i,
  output logic [NUM_CH*WIDTH-1:0]      data_o,
  output logic [NUM_CH*(LEN_LOG2+1)-1:0] level_o,
  output logic [NUM_CH-1:0]            rdy_o,
  output logic [NUM_CH-1:0]            ovf_o,
  output logic [NUM_CH-1:0]            udf_o
);

  localparam int LEN = 2 ** LEN_LOG2;
  localparam int LW  = LEN_LOG2 + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(LEN);
  localparam logic [LW-1:0] RDY_LEVEL  = LW'(READY_LEVEL);
  localparam logic          RDY_RST    = (READY_LEVEL == 0);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [WIDTH-1:0]    mem_q [LEN];
    logic [LEN_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d, raddr;
    logic [LW-1:0]       level_q, level_d;
    logic [WIDTH-1:0]    rdata_q, rdata_d;
    logic                rdy_q, rdy_d, ovf_q, ovf_d, udf_q, udf_d;
    logic                pop_ok, wr_ok;

    always_comb begin
      pop_ok  = pop_i[c] && (level_q != '0);
      // A full channel still accepts a write when the same cycle frees a slot.
      wr_ok   = we_i[c] && ((level_q != FULL_LEVEL) || pop_ok);
      raddr   = rptr_q + offset_i[c*LEN_LOG2 +: LEN_LOG2];
      rdata_d = mem_q[raddr];
      wptr_d  = wr_ok  ? wptr_q + 1'b1 : wptr_q;
      rptr_d  = pop_ok ? rptr_q + 1'b1 : rptr_q;
      level_d = level_q;
      if (wr_ok && !pop_ok) begin
        level_d = level_q + 1'b1;
      end else if (pop_ok && !wr_ok) begin
        level_d = level_q - 1'b1;
      end
      rdy_d = (level_d >= RDY_LEVEL);
      ovf_d = (we_i[c] && !wr_ok) || (ovf_q && !clr_flags_i[c]);
      udf_d = (pop_i[c] && (level_q == '0)) || (udf_q && !clr_flags_i[c]);
    end

    // Read and write share the edge, so a colliding read returns the old word.
    always_ff @(posedge clk) begin
      if (rst && wr_ok) begin
        mem_q[wptr_q] <= data_i[c*WIDTH +: WIDTH];
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        level_q <= '0;
        rdata_q <= '0;
        rdy_q   <= RDY_RST;
        ovf_q   <= 1'b0;
        udf_q   <= 1'b0;
      end else begin
        wptr_q  <= wptr_d;
        rptr_q  <= rptr_d;
        level_q <= level_d;
        rdata_q <= rdata_d;
        rdy_q   <= rdy_d;
        ovf_q   <= ovf_d;
        udf_q   <= udf_d;
      end
    end

    assign data_o[c*WIDTH +: WIDTH] = rdata_q;
    assign level_o[c*LW +: LW]      = level_q;
    assign rdy_o[c]                 = rdy_q;
    assign ovf_o[c]                 = ovf_q;
    assign udf_o[c]                 = udf_q;
  end

endmodule

// File: tb/tb_ringbuf_mc.sv
// tb/tb_ringbuf_mc.sv - self-checking bench for ringbuf_mc against a slot-array reference model
module tb_ringbuf_mc;
  localparam int NCH = 2;
  localparam int W   = 24;
  localparam int LL  = 6;
  localparam int LEN = 64;
  localparam int LW  = LL + 1;
  localparam int RL  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [NCH*W-1:0]    data_i;
  logic [NCH-1:0]      we_i, pop_i, clr_flags_i;
  logic [NCH*LL-1:0]   offset_i;
  logic [NCH*W-1:0]    data_o;
  logic [NCH*LW-1:0]   level_o;
  logic [NCH-1:0]      rdy_o, ovf_o, udf_o;

  ringbuf_mc #(.NUM_CH(NCH), .WIDTH(W), .LEN_LOG2(LL), .READY_LEVEL(RL)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .we_i(we_i), .pop_i(pop_i),
    .offset_i(offset_i), .clr_flags_i(clr_flags_i), .data_o(data_o),
    .level_o(level_o), .rdy_o(rdy_o), .ovf_o(ovf_o), .udf_o(udf_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: slot array per channel, indices advanced modulo LEN.
  logic [W-1:0] m_mem [NCH][LEN];
  bit           m_vld [NCH][LEN];
  int           m_wp [NCH], m_rp [NCH], m_lvl [NCH];
  logic [W-1:0] m_data [NCH];
  bit           m_dvld [NCH], m_ovf [NCH], m_udf [NCH];

  task automatic model_step();
    for (int c = 0; c < NCH; c++) begin
      int ra;
      bit ap, aw;
      if (!rst) begin
        m_wp[c] = 0; m_rp[c] = 0; m_lvl[c] = 0;
        m_data[c] = '0; m_dvld[c] = 1'b1; m_ovf[c] = 1'b0; m_udf[c] = 1'b0;
      end else begin
        ra = (m_rp[c] + int'(offset_i[c*LL +: LL])) % LEN;
        m_data[c] = m_mem[c][ra];
        m_dvld[c] = m_vld[c][ra];
        ap = pop_i[c] && (m_lvl[c] > 0);
        aw = we_i[c] && ((m_lvl[c] < LEN) || ap);
        m_ovf[c] = (we_i[c] && !aw) || (m_ovf[c] && !clr_flags_i[c]);
        m_udf[c] = (pop_i[c] && (m_lvl[c] == 0)) || (m_udf[c] && !clr_flags_i[c]);
        if (aw) begin
          m_mem[c][m_wp[c]] = data_i[c*W +: W];
          m_vld[c][m_wp[c]] = 1'b1;
          m_wp[c] = (m_wp[c] + 1) % LEN;
        end
        if (ap) m_rp[c] = (m_rp[c] + 1) % LEN;
        m_lvl[c] = m_lvl[c] + int'(aw) - int'(ap);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    we_i = '0; pop_i = '0; clr_flags_i = '0; offset_i = '0; data_i = '0; rst = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic push(input int c, input logic [W-1:0] v);
    we_i[c] = 1'b1;
    data_i[c*W +: W] = v;
    tick();
    we_i[c] = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    tick();
    for (int c = 0; c < NCH; c++) begin
      n_checks += 5;
      if (level_o[c*LW +: LW] !== '0) begin n_fail++; $display("FAIL reset_level ch%0d got %0d want 0", c, level_o[c*LW +: LW]); end
      if (rdy_o[c] !== 1'b0) begin n_fail++; $display("FAIL reset_rdy ch%0d got %0b want 0", c, rdy_o[c]); end
      if (data_o[c*W +: W] !== '0) begin n_fail++; $display("FAIL reset_data ch%0d got %h want 0", c, data_o[c*W +: W]); end
      if (ovf_o[c] !== 1'b0) begin n_fail++; $display("FAIL reset_ovf ch%0d got %0b want 0", c, ovf_o[c]); end
      if (udf_o[c] !== 1'b0) begin n_fail++; $display("FAIL reset_udf ch%0d got %0b want 0", c, udf_o[c]); end
    end
    rst = 1'b1;
  endtask

  task automatic test_readback();
    for (int i = 1; i <= 5; i++) push(0, W'(i));
    offset_i[0 +: LL] = LL'(2);
    tick();
    n_checks += 3;
    if (data_o[0 +: W] !== 24'h000003) begin n_fail++; $display("FAIL readback_data got %h want 000003", data_o[0 +: W]); end
    if (level_o[0 +: LW] !== LW'(5)) begin n_fail++; $display("FAIL readback_level0 got %0d want 5", level_o[0 +: LW]); end
    if (level_o[LW +: LW] !== '0) begin n_fail++; $display("FAIL readback_level1 got %0d want 0", level_o[LW +: LW]); end
    offset_i = '0;
  endtask

  task automatic test_ready();
    do_reset();
    for (int i = 0; i < 31; i++) push(0, W'(32'h100 + i));
    n_checks += 2;
    if (level_o[0 +: LW] !== LW'(31)) begin n_fail++; $display("FAIL ready_level31 got %0d want 31", level_o[0 +: LW]); end
    if (rdy_o[0] !== 1'b0) begin n_fail++; $display("FAIL ready_at31 got %0b want 0", rdy_o[0]); end
    push(0, W'(32'h100 + 31));
    n_checks += 2;
    if (level_o[0 +: LW] !== LW'(32)) begin n_fail++; $display("FAIL ready_level32 got %0d want 32", level_o[0 +: LW]); end
    if (rdy_o[0] !== 1'b1) begin n_fail++; $display("FAIL ready_at32 got %0b want 1", rdy_o[0]); end
  endtask

  task automatic test_overflow();
    for (int i = 32; i < LEN; i++) push(0, W'(32'h100 + i));
    n_checks += 2;
    if (level_o[0 +: LW] !== LW'(64)) begin n_fail++; $display("FAIL ovf_fill_level got %0d want 64", level_o[0 +: LW]); end
    if (ovf_o[0] !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %0b want 0", ovf_o[0]); end
    push(0, 24'hABCDEF);
    n_checks += 2;
    if (level_o[0 +: LW] !== LW'(64)) begin n_fail++; $display("FAIL ovf_level got %0d want 64", level_o[0 +: LW]); end
    if (ovf_o[0] !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %0b want 1", ovf_o[0]); end
    offset_i[0 +: LL] = LL'(63);
    tick();
    n_checks += 2;
    if (data_o[0 +: W] === 24'hABCDEF) begin n_fail++; $display("FAIL ovf_dropped got %h want not abcdef", data_o[0 +: W]); end
    if (data_o[0 +: W] !== 24'h00013F) begin n_fail++; $display("FAIL ovf_slot63 got %h want 00013f", data_o[0 +: W]); end
    offset_i = '0;
    clr_flags_i[0] = 1'b1;
    tick();
    clr_flags_i[0] = 1'b0;
    n_checks++;
    if (ovf_o[0] !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %0b want 0", ovf_o[0]); end
  endtask

  task automatic test_underflow();
    pop_i[1] = 1'b1; we_i[1] = 1'b1; data_i[W +: W] = 24'h123456;
    tick();
    pop_i[1] = 1'b0; we_i[1] = 1'b0;
    n_checks += 2;
    if (udf_o[1] !== 1'b1) begin n_fail++; $display("FAIL udf_set got %0b want 1", udf_o[1]); end
    if (level_o[LW +: LW] !== LW'(1)) begin n_fail++; $display("FAIL udf_level got %0d want 1", level_o[LW +: LW]); end
    tick();
    n_checks++;
    if (data_o[W +: W] !== 24'h123456) begin n_fail++; $display("FAIL udf_data got %h want 123456", data_o[W +: W]); end
    pop_i[1] = 1'b1;
    tick();
    clr_flags_i[1] = 1'b1;
    tick();
    pop_i[1] = 1'b0;
    n_checks += 2;
    if (udf_o[1] !== 1'b1) begin n_fail++; $display("FAIL udf_set_wins got %0b want 1", udf_o[1]); end
    if (level_o[LW +: LW] !== '0) begin n_fail++; $display("FAIL udf_empty got %0d want 0", level_o[LW +: LW]); end
    tick();
    clr_flags_i[1] = 1'b0;
    n_checks++;
    if (udf_o[1] !== 1'b0) begin n_fail++; $display("FAIL udf_clear got %0b want 0", udf_o[1]); end
  endtask

  task automatic test_full_pushpop();
    logic [W-1:0] last;
    last = '0;
    for (int i = 0; i < 10; i++) begin
      last = W'($urandom);
      we_i[0] = 1'b1; pop_i[0] = 1'b1; data_i[0 +: W] = last;
      tick();
      n_checks += 2;
      if (level_o[0 +: LW] !== LW'(64)) begin n_fail++; $display("FAIL pp_level cyc%0d got %0d want 64", i, level_o[0 +: LW]); end
      if (ovf_o[0] !== 1'b0) begin n_fail++; $display("FAIL pp_ovf cyc%0d got %0b want 0", i, ovf_o[0]); end
    end
    we_i[0] = 1'b0; pop_i[0] = 1'b0;
    offset_i[0 +: LL] = LL'(63);
    tick();
    n_checks++;
    if (data_o[0 +: W] !== last) begin n_fail++; $display("FAIL pp_last got %h want %h", data_o[0 +: W], last); end
    offset_i = '0;
  endtask

  task automatic test_stream();
    logic [W-1:0] exp_q [$];
    logic [W-1:0] v;
    do_reset();
    exp_q.delete();
    for (int i = 0; i < LEN; i++) begin
      v = W'($urandom);
      exp_q.push_back(v);
      push(0, v);
    end
    for (int k = 0; k < 8; k++) begin
      pop_i[0] = 1'b1;
      tick();
      pop_i[0] = 1'b0;
      v = exp_q.pop_front();
      n_checks++;
      if (data_o[0 +: W] !== v) begin n_fail++; $display("FAIL stream_pop k%0d got %h want %h", k, data_o[0 +: W], v); end
      v = W'($urandom);
      exp_q.push_back(v);
      push(0, v);
      for (int j = 0; j < 62; j++) begin
        tick();
        n_checks += 2;
        if (level_o[0 +: LW] < LW'(63) || level_o[0 +: LW] > LW'(65)) begin
          n_fail++; $display("FAIL stream_level k%0d got %0d want 63..65", k, level_o[0 +: LW]);
        end
        if ((ovf_o[0] | udf_o[0]) !== 1'b0) begin n_fail++; $display("FAIL stream_flags k%0d got %0b%0b want 00", k, ovf_o[0], udf_o[0]); end
      end
      n_checks++;
      if (data_o[0 +: W] !== exp_q[0]) begin n_fail++; $display("FAIL stream_head k%0d got %h want %h", k, data_o[0 +: W], exp_q[0]); end
    end
  endtask

  task automatic test_random();
    int p_we, p_pop;
    logic [LW-1:0] el;
    do_reset();
    p_we = 50; p_pop = 50;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc % 100 == 0) begin
        p_we  = 10 + 30 * int'($urandom_range(0, 2));
        p_pop = 100 - p_we;
      end
      rst = ($urandom_range(0, 399) != 0);
      for (int c = 0; c < NCH; c++) begin
        we_i[c] = ($urandom_range(0, 99) < p_we);
        pop_i[c] = ($urandom_range(0, 99) < p_pop);
        clr_flags_i[c] = ($urandom_range(0, 15) == 0);
        data_i[c*W +: W] = W'($urandom);
        offset_i[c*LL +: LL] = LL'($urandom_range(0, LEN - 1));
      end
      tick();
      for (int c = 0; c < NCH; c++) begin
        el = LW'(m_lvl[c]);
        n_checks += 4;
        if (level_o[c*LW +: LW] !== el) begin n_fail++; $display("FAIL rand_level ch%0d cyc%0d got %0d want %0d", c, cyc, level_o[c*LW +: LW], el); end
        if (rdy_o[c] !== (m_lvl[c] >= RL)) begin n_fail++; $display("FAIL rand_rdy ch%0d cyc%0d got %0b want %0b", c, cyc, rdy_o[c], m_lvl[c] >= RL); end
        if (ovf_o[c] !== m_ovf[c]) begin n_fail++; $display("FAIL rand_ovf ch%0d cyc%0d got %0b want %0b", c, cyc, ovf_o[c], m_ovf[c]); end
        if (udf_o[c] !== m_udf[c]) begin n_fail++; $display("FAIL rand_udf ch%0d cyc%0d got %0b want %0b", c, cyc, udf_o[c], m_udf[c]); end
        if (m_dvld[c]) begin
          n_checks++;
          if (data_o[c*W +: W] !== m_data[c]) begin n_fail++; $display("FAIL rand_data ch%0d cyc%0d got %h want %h", c, cyc, data_o[c*W +: W], m_data[c]); end
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    for (int c = 0; c < NCH; c++) begin
      for (int i = 0; i < LEN; i++) begin
        m_vld[c][i] = 1'b0;
        m_mem[c][i] = '0;
      end
    end
    idle_inputs();
    test_reset();
    test_readback();
    test_ready();
    test_overflow();
    test_underflow();
    test_full_pushpop();
    test_stream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
